// File: rtl/adder_tree_sched.sv
// Two-requester round-robin scheduler in front of a 4-stage pipelined 8-input
// unsigned adder tree; results return tagged with the owning requester.
module adder_tree_sched #(
  parameter int ADDER_WIDTH = 28
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req0_i,
  input  logic [8*ADDER_WIDTH-1:0]   ops0_i,
  output logic                       gnt0_o,
  input  logic                       req1_i,
  input  logic [8*ADDER_WIDTH-1:0]   ops1_i,
  output logic                       gnt1_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ADDER_WIDTH+2:0]     out_sum_o,
  output logic                       out_tag_o
);

  localparam int W = ADDER_WIDTH;

  logic                 advance;
  logic                 xfer;
  logic                 last_gnt_q, last_gnt_d;
  logic [8*W-1:0]       ops_sel;

  logic                 s0_valid_q, s0_tag_q;
  logic [W-1:0]         s0_op_q [8];
  logic                 s1_valid_q, s1_tag_q;
  logic [W:0]           s1_sum_q [4];
  logic [W:0]           s1_sum_d [4];
  logic                 s2_valid_q, s2_tag_q;
  logic [W+1:0]         s2_sum_q [2];
  logic [W+1:0]         s2_sum_d [2];
  logic                 out_valid_q, out_tag_q;
  logic [W+2:0]         out_sum_q;
  logic [W+2:0]         out_sum_d;

  assign advance = !out_valid_q || out_ready_i;

  // Tie goes to the requester that did not win the previous transfer.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!reset_i && advance) begin
      if (req0_i && req1_i) begin
        gnt0_o = last_gnt_q;
        gnt1_o = !last_gnt_q;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  assign xfer       = gnt0_o || gnt1_o;
  assign last_gnt_d = xfer ? gnt1_o : last_gnt_q;
  assign ops_sel    = gnt1_o ? ops1_i : ops0_i;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1_sum_d[i] = {1'b0, s0_op_q[2*i]} + {1'b0, s0_op_q[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      s2_sum_d[i] = {1'b0, s1_sum_q[2*i]} + {1'b0, s1_sum_q[2*i+1]};
    end
    out_sum_d = {1'b0, s2_sum_q[0]} + {1'b0, s2_sum_q[1]};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_gnt_q  <= 1'b1;
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_tag_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      if (advance) begin
        s0_valid_q  <= xfer;
        s1_valid_q  <= s0_valid_q;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        if (xfer) begin
          s0_tag_q <= gnt1_o;
          for (int k = 0; k < 8; k++) begin
            s0_op_q[k] <= ops_sel[k*W +: W];
          end
        end
        // Data only moves with a valid set so bubbles leave outputs untouched.
        if (s0_valid_q) begin
          s1_tag_q <= s0_tag_q;
          for (int i = 0; i < 4; i++) s1_sum_q[i] <= s1_sum_d[i];
        end
        if (s1_valid_q) begin
          s2_tag_q <= s1_tag_q;
          for (int i = 0; i < 2; i++) s2_sum_q[i] <= s2_sum_d[i];
        end
        if (s2_valid_q) begin
          out_tag_q <= s2_tag_q;
          out_sum_q <= out_sum_d;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_tag_o   = out_tag_q;

endmodule

// File: doc/adder_tree_sched.md
# adder_tree_sched

Two-requester scheduler wrapped around a pipelined 8-input adder tree. Each requester presents eight packed ADDER_WIDTH-bit operands with a req/gnt handshake. A round-robin arbiter admits at most one operand set per cycle into a 4-stage registered tree, and the full-precision sum returns tagged with its requester through a valid/ready output port. It sits between operand producers and the accumulation datapath, so several clients can share one adder tree.

## Interface
- ADDER_WIDTH, 28, width of each operand.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 has an operand set available.
- ops0  in  8*ADDER_WIDTH  requester 0 operands; operand k is at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
- gnt0  out  1  requester 0 set accepted this cycle (combinational).
- req1, ops1, gnt1  as above, for requester 1.
- out_valid  out  1  out_sum and out_tag are valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ADDER_WIDTH+3  unsigned sum of the eight operands.
- out_tag  out  1  index of the requester that owns out_sum.

## Operation
- Unsigned arithmetic, no overflow possible. Stage widths:
  - S0: operands, W bits each.
  - S1: four pair sums, W+1 bits.
  - S2: two quad sums, W+2 bits.
  - S3: one full sum, W+3 bits.
- Each stage carries a valid bit and a tag bit alongside its data.
- advance = !out_valid | out_ready.
  - All stages shift together when advance=1.
  - All stages hold when advance=0; bubbles are not compressed.
- Arbiter:
  - gnt0/gnt1 are one-hot or zero; both are 0 when advance=0 or reset=1.
  - Only one requester asserting req: it is granted.
  - Both asserting req: grant goes to the requester not pointed to by last_gnt.
  - last_gnt updates to the granted index on every transfer and holds otherwise.
- Transfer: reqN & gntN high at a rising edge. opsN and tag N load into S0 with valid=1.
- No transfer while advance=1: S0 loads valid=0.
- Requesters hold req and ops stable until granted. The arbiter does not depend on that for correctness.
- Reset:
  - All stage valid bits, out_valid, out_sum and out_tag clear to 0.
  - last_gnt resets to 1, so requester 0 wins the first tie.
  - Reset mid-operation discards in-flight sets silently; nothing is emitted for them.

## Timing
- Latency: transfer at edge t produces out_valid=1 with the sum in the cycle after edge t+3. That is 4 register stages: S0, S1, S2, S3=output.
- Throughput: one set per cycle with out_ready held high.
- Results leave in transfer order.
- Output stall: out_valid=1 with out_ready=0 holds out_sum and out_tag stable, and gnt0=gnt1=0 that same cycle.
- Output handshake completes when out_valid & out_ready.
  - With out_ready high and S2 holding a bubble, out_valid drops next cycle.
- Output values:
  - out_sum and out_tag are 0 after reset.
  - Otherwise they hold the last loaded value when out_valid=0. Verification checks them only when out_valid=1.
- Simultaneous req0 and req1 with advance=0: no grant, last_gnt unchanged.
- Reset asserted in the same cycle as req: no grant, and reset takes priority.

## Test plan
- Single set, W=28:
  - Stimulus: req0=1 for one cycle, all eight operands 0x FFFFFFF, out_ready=1.
  - Response: gnt0=1 in the same cycle; 4 cycles later out_valid=1 for exactly one cycle, out_sum=0x7FFFFFF8, out_tag=0.
- Contention:
  - Stimulus: req0 and req1 both held for 6 cycles; ops0 operands 1..8 (sum 36), ops1 all 0x100 (sum 0x800).
  - Response: grants 0,1,0,1,0,1; outputs on consecutive cycles alternate 36/tag0 and 0x800/tag1.
- Backpressure:
  - Stimulus: stream of 5 sets from requester 1 with out_ready low for 3 cycles once the first result appears.
  - Response: out_sum is held for those cycles; gnt1=0 while stalled; all 5 results arrive in order with none lost or duplicated.
- Reset mid-flight:
  - Stimulus: 3 sets in flight, then reset pulsed for 1 cycle.
  - Response: out_valid=0 from the cycle after reset with no stale result ever emitted; the next tie is granted to requester 0.
- Sparse input:
  - Stimulus: req0 high every other cycle with random operands.
  - Response: out_valid toggles with the same spacing; every out_sum matches the reference sum of its eight operands, width W+3.
